// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatcher between the HPS instruction PIO and the filter coprocessor.
// Decodes a start-edge-qualified instruction word, issues a valid/ready command and reports status.
module instr_dispatch_fsm #(
  parameter int NUM_OPCODES  = 8,
  parameter int LONG_OP_BASE = 4,
  parameter int TIMEOUT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_opcode,
  output logic [10:0] cmd_addr,
  output logic [15:0] cmd_data,
  input  logic        op_done,
  output logic [31:0] status_word
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [4:0] NUM_OP_LIM  = 5'(NUM_OPCODES);
  localparam logic [4:0] LONG_OP_LIM = 5'(LONG_OP_BASE);
  // Value the wait counter holds on the cycle whose increment would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WAIT_ALMOST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                 state_q;
  logic                   start_prev_q;
  logic                   cmd_valid_q;
  logic [3:0]             opcode_q;
  logic [10:0]            addr_q;
  logic [15:0]            data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic                   timeout_q;
  logic [3:0]             last_op_q;
  logic [15:0]            count_q;
  logic [TIMEOUT_W-1:0]   wait_cnt_q;

  logic start_rise;
  logic op_illegal;
  logic op_long;

  assign start_rise = instr_word[31] & ~start_prev_q;
  assign op_illegal = {1'b0, opcode_q} >= NUM_OP_LIM;
  assign op_long    = {1'b0, opcode_q} >= LONG_OP_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      opcode_q     <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      last_op_q    <= '0;
      count_q      <= '0;
      wait_cnt_q   <= '0;
    end else begin
      start_prev_q <= instr_word[31];
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            opcode_q  <= instr_word[30:27];
            addr_q    <= instr_word[26:16];
            data_q    <= instr_word[15:0];
            last_op_q <= instr_word[30:27];
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (op_illegal) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            count_q <= count_q + 16'd1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_ISSUE;
          end
        end

        // cmd_valid rises on the first ISSUE cycle and is held until accepted.
        S_ISSUE: begin
          if (cmd_valid_q && cmd_ready) begin
            cmd_valid_q <= 1'b0;
            if (op_long) begin
              wait_cnt_q <= '0;
              state_q    <= S_WAIT;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              count_q <= count_q + 16'd1;
              state_q <= S_DONE;
            end
          end else begin
            cmd_valid_q <= 1'b1;
          end
        end

        S_WAIT: begin
          if (op_done) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            count_q <= count_q + 16'd1;
            state_q <= S_DONE;
          end else if (wait_cnt_q == WAIT_ALMOST) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            timeout_q  <= 1'b1;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            count_q    <= count_q + 16'd1;
            state_q    <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        // A held start bit must be released before another instruction is accepted.
        S_DONE: begin
          if (!instr_word[31]) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = opcode_q;
  assign cmd_addr    = addr_q;
  assign cmd_data    = data_q;
  assign status_word = {count_q, 8'h00, last_op_q, timeout_q, error_q, done_q, busy_q};

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Bench for instr_dispatch_fsm: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a timing-based behavioural model.
module tb_instr_dispatch_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [10:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        op_done;
  logic [31:0] status_word;

  instr_dispatch_fsm #(
    .NUM_OPCODES (8),
    .LONG_OP_BASE(4),
    .TIMEOUT_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_word (instr_word),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .op_done    (op_done),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [10:0] a, input logic [15:0] d);
    return {1'b1, op, a, d};
  endfunction

  // Behavioural model: tracks an instruction by its age since latch and since handshake.
  bit          m_live = 1'b0;
  bit          m_prev;
  int          m_phase;   // 0 waiting for start, 1 running, 2 finished
  int          m_age;
  int          m_hs;      // cycles since handshake of a long op, -1 before handshake
  bit          m_vld;
  logic [3:0]  m_op;
  logic [10:0] m_addr;
  logic [15:0] m_data;
  bit          m_busy, m_done, m_err, m_to;
  logic [3:0]  m_last;
  logic [15:0] m_cnt;

  task automatic m_finish();
    m_busy  = 1'b0;
    m_done  = 1'b1;
    m_cnt   = m_cnt + 16'd1;
    m_vld   = 1'b0;
    m_phase = 2;
    $display("[TB] txn op=%0d addr=0x%03h data=0x%04h err=%0d to=%0d count=%0d",
             m_op, m_addr, m_data, m_err, m_to, m_cnt);
  endtask

  task automatic model_step();
    bit rise;
    if (reset) begin
      m_live = 1'b1; m_prev = 1'b0; m_phase = 0; m_age = 0; m_hs = -1; m_vld = 1'b0;
      m_op = '0; m_addr = '0; m_data = '0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_to = 1'b0; m_last = '0; m_cnt = '0;
      return;
    end
    rise = instr_word[31] & ~m_prev;
    case (m_phase)
      0: if (rise) begin
        m_op = instr_word[30:27]; m_addr = instr_word[26:16]; m_data = instr_word[15:0];
        m_last = m_op; m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_to = 1'b0;
        m_phase = 1; m_age = 0; m_hs = -1; m_vld = 1'b0;
      end
      1: begin
        m_age++;
        if (m_op >= 8) begin
          m_err = 1'b1;
          m_finish();
        end else if (m_hs < 0) begin
          if (m_vld && cmd_ready) begin
            m_vld = 1'b0;
            if (m_op >= 4) m_hs = 0;
            else m_finish();
          end else if (m_age >= 2) begin
            m_vld = 1'b1;
          end
        end else begin
          m_hs++;
          if (op_done) m_finish();
          else if (m_hs == 15) begin
            m_to = 1'b1; m_err = 1'b1;
            m_finish();
          end
        end
      end
      default: if (!instr_word[31]) m_phase = 0;
    endcase
    m_prev = instr_word[31];
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_valid",  32'(cmd_valid),  32'(m_vld));
      check("cyc_opcode", 32'(cmd_opcode), 32'(m_op));
      check("cyc_addr",   32'(cmd_addr),   32'(m_addr));
      check("cyc_data",   32'(cmd_data),   32'(m_data));
      check("cyc_status", status_word, {m_cnt, 8'h00, m_last, m_to, m_err, m_done, m_busy});
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] r;
    reset = 1'b1; instr_word = '0; cmd_ready = 1'b1; op_done = 1'b0;
    tick(); tick();
    check("reset_status", status_word, 32'h0);
    check("reset_valid", 32'(cmd_valid), 32'h0);
    reset = 1'b0;
    tick();

    // Short op, ready tied high
    instr_word = 32'h8000_1234;
    tick(); tick(); tick();
    check("short_valid", 32'(cmd_valid), 32'h1);
    check("short_data", 32'(cmd_data), 32'h1234);
    check("short_opcode", 32'(cmd_opcode), 32'h0);
    tick();
    check("short_valid_drop", 32'(cmd_valid), 32'h0);
    check("short_status", status_word, 32'h0001_0002);
    instr_word = '0; tick();

    // Backpressure, with instr_word fields scrambled after latch
    cmd_ready = 1'b0;
    instr_word = mk(4'd2, 11'h155, 16'hBEEF);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(cmd_valid), 32'h1);
      check("bp_data_stable", 32'(cmd_data), 32'hBEEF);
      check("bp_addr_stable", 32'(cmd_addr), 32'h155);
      check("bp_busy", status_word, 32'h0001_0021);
      r = $urandom;
      instr_word = {1'b1, r[30:0]};
      tick();
    end
    check("bp_valid_last", 32'(cmd_valid), 32'h1);
    cmd_ready = 1'b1;
    tick();
    check("bp_valid_drop", 32'(cmd_valid), 32'h0);
    check("bp_status", status_word, 32'h0002_0022);
    instr_word = '0; tick();

    // Long op with op_done 10 cycles after handshake
    instr_word = mk(4'd5, 11'h0, 16'h0042);
    tick(); tick(); tick();
    check("long_valid", 32'(cmd_valid), 32'h1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("long_busy", status_word, 32'h0002_0051);
      if (i < 9) tick();
    end
    op_done = 1'b1; tick(); op_done = 1'b0;
    check("long_status", status_word, 32'h0003_0052);
    instr_word = '0; tick();

    // Illegal opcode
    instr_word = mk(4'd9, 11'h7FF, 16'hFFFF);
    tick(); tick();
    check("illegal_valid", 32'(cmd_valid), 32'h0);
    check("illegal_status", status_word, 32'h0004_0096);
    tick();
    check("illegal_valid2", 32'(cmd_valid), 32'h0);
    instr_word = '0; tick();

    // Timeout on a long op with no op_done
    instr_word = mk(4'd6, 11'h1, 16'h1);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 15; i++) begin
      check("to_busy", status_word, 32'h0004_0061);
      tick();
    end
    check("to_status", status_word, 32'h0005_006E);
    instr_word = '0; tick();

    // Start held high across DONE, then dropped and raised again
    w = mk(4'd1, 11'h0AA, 16'h5555);
    instr_word = w;
    tick(); tick(); tick(); tick();
    check("held_first", status_word, 32'h0006_0012);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_no_valid", 32'(cmd_valid), 32'h0);
      check("held_status", status_word, 32'h0006_0012);
    end
    instr_word = '0; tick();
    instr_word = w;
    tick(); tick(); tick(); tick();
    check("held_second", status_word, 32'h0007_0012);
    instr_word = '0; tick();

    // Reset during ISSUE
    cmd_ready = 1'b0;
    instr_word = mk(4'd3, 11'h3, 16'h3);
    tick(); tick(); tick();
    check("rst_pre_valid", 32'(cmd_valid), 32'h1);
    reset = 1'b1; instr_word = '0;
    tick();
    check("rst_mid_valid", 32'(cmd_valid), 32'h0);
    check("rst_mid_status", status_word, 32'h0);
    tick();
    check("rst_mid_status2", status_word, 32'h0);
    reset = 1'b0; cmd_ready = 1'b1;
    tick();

    // Randomized traffic, checked by the per-cycle compare process
    for (int c = 0; c < 4000; c++) begin
      cmd_ready = ($urandom_range(0, 3) != 0);
      op_done   = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom;
        instr_word[30:0] = r[30:0];
      end
      if ($urandom_range(0, 5) == 0) instr_word[31] = ~instr_word[31];
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
